// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the ripple-counter monitor.
package count_monitor_pkg;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  localparam int SYNC_STAGES  = 2;
  localparam int STEP_TOTAL_W = 16;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int stab_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, one independent chain per bit, synchronous active-high reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Ripple-counter monitor: synchronize, stability-filter, commit and classify each change.
// Optional macro COUNT_MONITOR_STATS_EN adds the 16-bit step_total output. STABLE_CYCLES >= 1.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             step_pulse,
  output logic             dir,
  output logic             wrap_pulse,
  output logic             skip_err
`ifdef COUNT_MONITOR_STATS_EN
  ,
  output logic [STEP_TOTAL_W-1:0] step_total
`endif
);

  localparam int             SW       = stab_w(STABLE_CYCLES);
  localparam logic [SW-1:0]  STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0]       s;
  logic [WIDTH-1:0]       prev;
  logic [SW-1:0]          stab_cnt;
  logic [SYNC_STAGES:0]   fill;
  logic                   stable_pair;
  logic                   commit;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       cnt_nxt;
  logic [WIDTH-1:0]       cnt_inc, cnt_dec;
  logic                   valid_nxt, dir_nxt, step_nxt, wrap_nxt, set_err, err_nxt;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cnt_in),
    .q   (s)
  );

  // The reset-cleared sync and prev flops hold no real sample; fill tracks when
  // prev first carries a post-reset value so zeros left by reset never qualify.
  assign stable_pair = (s == prev) && fill[SYNC_STAGES];
  assign commit      = stable_pair && (stab_cnt == STAB_MAX) &&
                       ((s != cnt_out) || (state == S_INIT));

  // NOTE: every flop, including the sample pipeline, is reset so a mid-run reset drops pending work.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      stab_cnt <= '0;
      fill     <= '0;
    end else begin
      prev <= s;
      fill <= {fill[SYNC_STAGES-1:0], 1'b1};
      if (!stable_pair)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign cnt_inc = cnt_out + WIDTH'(1);
  assign cnt_dec = cnt_out - WIDTH'(1);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_out;
    valid_nxt = cnt_valid;
    dir_nxt   = dir;
    step_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    set_err   = 1'b0;
    case (state)
      S_INIT: begin
        if (commit) begin
          cnt_nxt   = s;
          valid_nxt = 1'b1;
          state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        if (commit) begin
          cnt_nxt = s;
          if (s == cnt_inc) begin
            step_nxt = 1'b1;
            dir_nxt  = 1'b1;
            wrap_nxt = (cnt_out == CNT_MAX);
          end else if (s == cnt_dec) begin
            step_nxt = 1'b1;
            dir_nxt  = 1'b0;
            wrap_nxt = (cnt_out == '0);
          end else begin
            set_err = 1'b1;
          end
        end
      end
      default: state_nxt = S_INIT;
    endcase
    err_nxt = set_err | (skip_err & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      cnt_out    <= '0;
      cnt_valid  <= 1'b0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      skip_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt_out    <= cnt_nxt;
      cnt_valid  <= valid_nxt;
      dir        <= dir_nxt;
      step_pulse <= step_nxt;
      wrap_pulse <= wrap_nxt;
      skip_err   <= err_nxt;
    end
  end

`ifdef COUNT_MONITOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      step_total <= '0;
    else if (step_nxt)
      step_total <= step_total + 1'b1;
  end
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: a history-based reference model predicts every cycle's outputs.
module tb_count_monitor;

  localparam int W = 4;
  localparam int K = 2;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cnt_in;
  logic         clr_err;
  logic [W-1:0] cnt_out;
  logic         cnt_valid, step_pulse, dir, wrap_pulse, skip_err;
`ifdef COUNT_MONITOR_STATS_EN
  logic [15:0]  step_total;
`endif

  count_monitor #(.WIDTH(W), .STABLE_CYCLES(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .clr_err    (clr_err),
    .cnt_out    (cnt_out),
    .cnt_valid  (cnt_valid),
    .step_pulse (step_pulse),
    .dir        (dir),
    .wrap_pulse (wrap_pulse),
    .skip_err   (skip_err)
`ifdef COUNT_MONITOR_STATS_EN
    ,
    .step_total (step_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int valid;
    int step;
    int dir;
    int wrap;
    int skip;
    int total;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: a value is committed once STABLE_CYCLES+1 consecutive
  // post-reset samples of cnt_in agree, seen through the two sync stages.
  initial begin
    int   hist[$];
    exp_t m;
    bit   init;
    bit   commit;
    int   v;
    m    = '{default: 0};
    init = 1'b1;
    forever begin
      @(posedge clk);
      if (rst) begin
        hist.delete();
        m    = '{default: 0};
        init = 1'b1;
      end else begin
        m.step = 0;
        m.wrap = 0;
        commit = 1'b0;
        v      = 0;
        if (hist.size() >= K + 2) begin
          v      = hist[1];
          commit = 1'b1;
          for (int j = 2; j <= K + 1; j++)
            if (hist[j] != v) commit = 1'b0;
          if (!init && v == m.cnt) commit = 1'b0;
        end
        if (clr_err) m.skip = 0;
        if (commit) begin
          if (init) begin
            init    = 1'b0;
            m.valid = 1;
          end else if (v == (m.cnt + 1) % M) begin
            m.step = 1;
            m.dir  = 1;
            m.wrap = (m.cnt == M - 1);
          end else if (v == (m.cnt + M - 1) % M) begin
            m.step = 1;
            m.dir  = 0;
            m.wrap = (m.cnt == 0);
          end else begin
            m.skip = 1;
          end
          if (m.step) m.total = (m.total + 1) % 65536;
          m.cnt = v;
        end
        hist.push_front(int'(cnt_in));
        if (hist.size() > K + 3) void'(hist.pop_back());
      end
      sb.push_back(m);
    end
  end

  // Monitor: every cycle the DUT presents a full output set, compared against the next model record.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty at %0t: got no prediction, required one", $time);
      end else begin
        e = sb.pop_front();
        check("cnt_out",    int'(cnt_out),    e.cnt);
        check("cnt_valid",  int'(cnt_valid),  e.valid);
        check("step_pulse", int'(step_pulse), e.step);
        check("dir",        int'(dir),        e.dir);
        check("wrap_pulse", int'(wrap_pulse), e.wrap);
        check("skip_err",   int'(skip_err),   e.skip);
`ifdef COUNT_MONITOR_STATS_EN
        check("step_total", int'(step_total), e.total);
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input int v, input int n);
    cnt_in = W'(v);
    cyc(n);
  endtask

  initial begin
    int cur;
    int edges;
    rst     = 1'b1;
    cnt_in  = '0;
    clr_err = 1'b0;
    cyc(3);

    // First value after reset: committed on the fifth edge, nothing flagged.
    rst    = 1'b0;
    cnt_in = W'(3);
    edges  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cnt_valid) begin
        edges = i;
        break;
      end
    end
    check("init_latency", edges, 5);
    check("init_value", int'(cnt_out), 3);
    check("init_no_err", int'(skip_err), 0);
    cyc(5);

    hold(4, 10);
    hold(5, 10);
    for (int v = 6; v <= 15; v++) hold(v, 6);
    hold(0, 10);
    hold(15, 10);

    // Ripple glitch: short-lived 6 and 4 must never commit.
    hold(7, 10);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    hold(6, 1);
    hold(4, 2);
    hold(8, 10);

    // Skip, then a clear landing on the commit edge of another skip.
    hold(5, 10);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    hold(9, 10);
    cnt_in = W'(2);
    cyc(4);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    cyc(5);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;

    // Reset in the middle of qualifying 3.
    hold(3, 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    hold(3, 10);

    cur = 3;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: cur = (cur + 1) % M;
        3, 4, 5: cur = (cur + M - 1) % M;
        6, 7:    cur = int'($urandom_range(0, M - 1));
        default: ;
      endcase
      clr_err = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      hold(cur, int'($urandom_range(1, 7)));
      rst     = 1'b0;
    end
    clr_err = 1'b0;
    cyc(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
Downstream consumer of the 4-bit ripple counter output. Samples the counter's asynchronous, glitch-prone outputs into the system clock domain, rejects ripple transients by requiring a stable value, and publishes a clean registered count. Classifies each committed change as an up step, a down step, a wrap, or an illegal skip, so lab benches and display logic can use the counter safely.

Parameters:
WIDTH, 4, width of the monitored count.
STABLE_CYCLES, 2, number of consecutive identical synchronized samples required before a value is committed (must be >= 1).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
cnt_in  input  WIDTH  raw counter value from the ripple counter (asynchronous to clk)
clr_err  input  1  clears skip_err
cnt_out  output  WIDTH  committed, glitch-free count
cnt_valid  output  1  high once the first stable value has been committed
step_pulse  output  1  one-cycle pulse when a legal ±1 step is committed
dir  output  1  direction of the last legal step: 1 = up, 0 = down
wrap_pulse  output  1  one-cycle pulse on a max->0 or 0->max legal step
skip_err  output  1  sticky flag: a committed change was not ±1 (mod 2^WIDTH)

Behaviour:
- Reset, synchronous: cnt_out=0, cnt_valid=0, dir=0, step_pulse=0, wrap_pulse=0, skip_err=0. Synchronizer flops, sample register and stability counter = 0. State = S_INIT. Reset asserted mid-operation aborts any pending qualification.
- Synchronizer: cnt_in passes through 2 flops to give s. Each bus bit is synchronized independently; bus incoherence is handled by the stability filter.
- Stability: register prev <= s every cycle. stab_cnt resets to 0 when s != prev. Otherwise it increments, saturating at STABLE_CYCLES-1.
- Commit condition: s == prev, stab_cnt == STABLE_CYCLES-1, and (s != cnt_out or state == S_INIT). On commit, cnt_out <= s on the same edge.
- Latency: a value held on cnt_in appears on cnt_out exactly 3+STABLE_CYCLES rising edges after it changes (5 edges at default). A value that changes before qualifying is never committed.
- State S_INIT: the first commit loads cnt_out, sets cnt_valid=1 and moves to S_TRACK. No step, wrap or error is reported on this commit, even if the value equals 0.
- State S_TRACK, on commit (old = cnt_out):
  - s == old+1 mod 2^WIDTH: step_pulse=1, dir=1. wrap_pulse=1 if old == 2^WIDTH-1.
  - s == old-1 mod 2^WIDTH: step_pulse=1, dir=0. wrap_pulse=1 if old == 0.
  - Any other value: skip_err=1, dir held, no step_pulse or wrap_pulse. cnt_out still updates, so tracking resynchronizes.
- Pulses are registered and high for exactly one cycle, aligned with the cnt_out update. They are 0 in all non-commit cycles.
- skip_err clears when clr_err=1. If set and clear occur in the same cycle, set wins.
- The block never returns to S_INIT except through rst.
- Arithmetic is modulo 2^WIDTH; the ±1 comparisons use WIDTH-bit wrap.

Optional Feature:
COUNT_MONITOR_STATS_EN
- Defined: adds output step_total (16 bits). It increments on every step_pulse, wraps at 0xFFFF->0, and resets to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package count_monitor_pkg: state enum {S_INIT, S_TRACK}, SYNC_STAGES=2 constant, STEP_TOTAL_W=16.
- One sub-module: sync_2ff, a WIDTH-parameterized two-flop synchronizer with synchronous reset. Instantiated once for cnt_in.

Test Plan:
- Reset, then cnt_in held at 4'd3 -> cnt_out=3 and cnt_valid=1 on edge 5 after release; no pulses, skip_err=0.
- From 3, drive 4 then 5, each held 10 cycles -> two step_pulse, dir=1, cnt_out 4 then 5, wrap_pulse=0.
- From 15, drive 0 -> step_pulse=1, wrap_pulse=1, dir=1. Then from 0, drive 15 -> step_pulse=1, wrap_pulse=1, dir=0.
- Ripple glitch: from 7, drive 6 for 1 cycle, then 4 for 2 cycles, then 8 held -> only 8 is committed. step_pulse=1, dir=1, no skip_err.
- Skip: from 5, drive 9 -> skip_err=1, cnt_out=9, no step_pulse. Assert clr_err while driving 2 simultaneously -> skip_err stays 1. Then clr_err alone -> skip_err=0.
- Assert rst mid-qualification (cnt_in just changed 2->3) -> all outputs 0 next edge, state S_INIT; with COUNT_MONITOR_STATS_EN defined, step_total=0.
